// File: rtl/fsm_par_mux_arbiter_if.sv
// Bundle of the requester, checker-feedback and framed-bus signals.
// The arbiter takes the master side. A testbench or the checker takes the slave side.
interface fsm_par_mux_arbiter_if #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int NUM_REQ   = 4
);
  localparam int PAYLOAD_W = BUS_SIZE - 2 * WORD_SIZE;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*PAYLOAD_W-1:0] payload_in;
  logic                         error;
  logic [NUM_REQ-1:0]           gnt;
  logic [BUS_SIZE-1:0]          bus_data_in;
  logic                         bus_valid;
  logic [1:0]                   state_control;
  logic [WORD_SIZE-1:0]         seq;
  logic [7:0]                   err_cnt;

  modport master (
    input  req, payload_in, error,
    output gnt, bus_data_in, bus_valid, state_control, seq, err_cnt
  );

  modport slave (
    output req, payload_in, error,
    input  gnt, bus_data_in, bus_valid, state_control, seq, err_cnt
  );
endinterface

// File: rtl/fsm_par_mux_arbiter.sv
// Round-robin arbiter that frames the winning payload as {0xF, payload, seq} for the checker.
// After a checker error, it backs off for HOLD_CYCLES and restarts the sequence at 0.
module fsm_par_mux_arbiter #(
  parameter int BUS_SIZE    = 16,
  parameter int WORD_SIZE   = 4,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 4
) (
  input logic                 clk,
  input logic                 reset,
  fsm_par_mux_arbiter_if.master bus
);
  localparam int PAYLOAD_W = BUS_SIZE - 2 * WORD_SIZE;
  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HOLD = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] seq_q, seq_d;
  logic [3:0]           hold_q, hold_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [BUS_SIZE-1:0]  data_q, data_d;
  logic                 valid_q, valid_d;

  logic [PAYLOAD_W-1:0] slice [NUM_REQ];
  logic                 grant_en;
  logic                 found;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     idx_p;
  logic [NUM_REQ-1:0]   gnt_c;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = bus.payload_in[gi*PAYLOAD_W +: PAYLOAD_W];
  end

  // Grant logic: scan upward from ptr and wrap around. The first requester found wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    idx_p    = '0;
    gnt_c    = '0;
    grant_en = !reset && !bus.error && (state_q != HOLD);
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_p = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (grant_en && !found && bus.req[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
    if (found) gnt_c[win] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    seq_d     = seq_q;
    hold_d    = hold_q;
    err_cnt_d = err_cnt_q;
    data_d    = '0;
    valid_d   = 1'b0;
    if (bus.error) begin
      // An error takes priority over everything else. Any pending request is ignored and ptr keeps its value.
      state_d   = HOLD;
      hold_d    = 4'(HOLD_CYCLES - 1);
      seq_d     = '0;
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end else if (state_q == HOLD) begin
      if (hold_q == 4'd0) state_d = IDLE;
      else                hold_d  = hold_q - 4'd1;
    end else if (found) begin
      data_d  = {{WORD_SIZE{1'b1}}, slice[win], seq_q};
      valid_d = 1'b1;
      seq_d   = seq_q + 1'b1;
      ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
      state_d = SEND;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      seq_q     <= '0;
      hold_q    <= '0;
      err_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      seq_q     <= seq_d;
      hold_q    <= hold_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.gnt           = gnt_c;
  assign bus.bus_data_in   = data_q;
  assign bus.bus_valid     = valid_q;
  assign bus.state_control = state_q;
  assign bus.seq           = seq_q;
  assign bus.err_cnt       = err_cnt_q;
endmodule
